// File: rtl/instr_prefetch_unit.sv
// Fetch stage: streams program nibbles into a small FIFO and assembles opcode+operand instructions (1+len cycles after push).
// Fetch stalls when the FIFO would overfill; ins_valid holds until ins_ready. PREFETCH_HLT_STOP_EN stops fetch at HLT.
module instr_prefetch_unit #(
  parameter int WIDTH = 4,
  parameter int ADDRSIZE = 8,
  parameter int DEPTH = 4,
  parameter logic [ADDRSIZE-1:0] RST_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_rd,
  output logic [ADDRSIZE-1:0] mem_addr,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDRSIZE-1:0] redirect_pc,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic [WIDTH-1:0]    ins_op,
  output logic [ADDRSIZE-1:0] ins_opnd,
  output logic [1:0]          ins_len,
  output logic [ADDRSIZE-1:0] ins_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Opcode encoding shared with the execute stage (HLT = 4'hF).
  localparam logic [WIDTH-1:0] OP_MVA = WIDTH'(7);
  localparam logic [WIDTH-1:0] OP_MVB = WIDTH'(8);
  localparam logic [WIDTH-1:0] OP_JMP = WIDTH'(9);
  localparam logic [WIDTH-1:0] OP_JZ  = WIDTH'(10);
  localparam logic [WIDTH-1:0] OP_JNZ = WIDTH'(11);

  typedef struct packed {
    logic [ADDRSIZE-1:0] pc;
    logic [WIDTH-1:0]    dat;
  } ent_t;

  typedef enum logic [2:0] {S_IDLE, S_OP, S_LO, S_HI, S_HOLD} state_t;

  state_t              state, state_nx;
  ent_t                fifo [DEPTH];
  ent_t                head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         occ;
  logic [ADDRSIZE-1:0] fetch_pc, infl_addr;
  logic                infl, push, pop, fifo_empty, halted, halt_set;
  logic [1:0]          head_len;

  function automatic logic [1:0] op_len(input logic [WIDTH-1:0] op);
    case (op)
      OP_MVA, OP_MVB:         return 2'd1;
      OP_JMP, OP_JZ, OP_JNZ:  return 2'd2;
      default:                return 2'd0;
    endcase
  endfunction

  assign head       = fifo[rd_ptr];
  assign head_len   = op_len(head.dat);
  assign fifo_empty = (count == '0);
  // In-flight read counts against capacity so its data always has a slot.
  assign occ        = {1'b0, count} + {{CW{1'b0}}, infl};
  assign mem_rd     = !reset && !redirect_valid && !halted && (occ < DEPTH_C);
  assign mem_addr   = reset ? '0 : fetch_pc;
  assign push       = infl && !redirect_valid && !halted;
  assign ins_valid  = (state == S_HOLD);

`ifdef PREFETCH_HLT_STOP_EN
  localparam logic [WIDTH-1:0] OP_HLT = WIDTH'(15);
  assign halt_set = pop && (state == S_IDLE || state == S_OP) && (head.dat == OP_HLT);
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) halted <= 1'b0;
    else if (halt_set)           halted <= 1'b1;
  end
`else
  assign halt_set = 1'b0;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: infl_addr, dat: mem_rdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RST_PC;
      infl      <= 1'b0;
      infl_addr <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (redirect_valid)  fetch_pc <= redirect_pc;
      else if (mem_rd)     fetch_pc <= fetch_pc + 1'b1;
      infl      <= mem_rd;
      infl_addr <= fetch_pc;
      if (redirect_valid || halt_set) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE, S_OP: if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = (head_len == 2'd0) ? S_HOLD : S_LO;
      end
      S_LO: if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = (ins_len == 2'd2) ? S_HI : S_HOLD;
      end
      S_HI: if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = S_HOLD;
      end
      S_HOLD: if (ins_ready) state_nx = fifo_empty ? S_IDLE : S_OP;
      default: state_nx = S_IDLE;
    endcase
    if (redirect_valid) begin
      pop      = 1'b0;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ins_op   <= '0;
      ins_opnd <= '0;
      ins_len  <= '0;
      ins_pc   <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        case (state)
          S_IDLE, S_OP: begin
            ins_op   <= head.dat;
            ins_pc   <= head.pc;
            ins_len  <= head_len;
            ins_opnd <= '0;
          end
          S_LO:    ins_opnd[0 +: WIDTH]     <= head.dat;
          S_HI:    ins_opnd[WIDTH +: WIDTH] <= head.dat;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: program-memory model plus an instruction-stream model derived from program contents.
module tb_instr_prefetch_unit;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, MAB = 4'h6, MVA = 4'h7,
                         MVB = 4'h8, JMP = 4'h9, JZ = 4'hA, JNZ = 4'hB, HLT = 4'hF;

  logic       clk = 1'b0, reset = 1'b1, mem_rd, redirect_valid = 1'b0, ins_valid, ins_ready = 1'b0;
  logic [7:0] mem_addr, redirect_pc = 8'h00, ins_opnd, ins_pc;
  logic [3:0] mem_rdata = 4'h0, ins_op;
  logic [1:0] ins_len;
  logic [3:0] prog [256];

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] opnd;
    logic [1:0] len;
    logic [7:0] pc;
  } ins_t;

  ins_t dq[$];
  int n_total = 0, n_pass = 0, n_reads = 0;
  logic [7:0] last_rd = 8'h00;

  instr_prefetch_unit dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins_op(ins_op), .ins_opnd(ins_opnd), .ins_len(ins_len), .ins_pc(ins_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_rd ? prog[mem_addr] : 4'h0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int len_of(input logic [3:0] op);
    if (op == MVA || op == MVB) return 1;
    if (op == JMP || op == JZ || op == JNZ) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] all_outs();
    return {mem_rd, mem_addr, ins_valid, ins_op, ins_opnd, ins_len, ins_pc};
  endfunction

  // Stream model: the next delivered instruction is whatever the program holds at exp_pc.
  logic [7:0] exp_pc = 8'h00, exp_fa = 8'h00;
  bit   prev_hold = 1'b0;
  ins_t prev_ins, cur, e;
  int   l;

  always @(negedge clk) begin
    #4;
    if (reset) begin
      exp_pc    = 8'h00;
      exp_fa    = 8'h00;
      prev_hold = 1'b0;
    end else begin
      cur = '{ins_op, ins_opnd, ins_len, ins_pc};
      if (prev_hold)
        check(ins_valid === 1'b1 && cur === prev_ins, "hold_stable", {10'b0, cur}, {10'b0, prev_ins});
      if (mem_rd) begin
        check(mem_addr === exp_fa, "fetch_addr", {24'b0, mem_addr}, {24'b0, exp_fa});
        exp_fa  = exp_fa + 8'd1;
        n_reads++;
        last_rd = mem_addr;
      end
      if (ins_valid && ins_ready) begin
        l      = len_of(prog[exp_pc]);
        e.op   = prog[exp_pc];
        e.len  = 2'(l);
        e.pc   = exp_pc;
        e.opnd = (l == 0) ? 8'h00 :
                 (l == 1) ? {4'h0, prog[8'(exp_pc + 8'd1)]} :
                            {prog[8'(exp_pc + 8'd2)], prog[8'(exp_pc + 8'd1)]};
        check(cur === e, "deliver", {10'b0, cur}, {10'b0, e});
        dq.push_back(cur);
        exp_pc = exp_pc + 8'(1 + l);
      end
      if (redirect_valid) begin
        check(mem_rd === 1'b0, "rd_during_redirect", {31'b0, mem_rd}, 32'd0);
        exp_pc = redirect_pc;
        exp_fa = redirect_pc;
      end
      prev_hold = ins_valid && !ins_ready && !redirect_valid;
      prev_ins  = cur;
    end
  end

  task automatic wait_deliv(input int n, input string name);
    int c = 0;
    while (dq.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(dq.size() >= n, name, dq.size(), n);
  endtask

  task automatic check_ins(input int idx, input logic [3:0] op, input logic [7:0] opnd,
                           input logic [1:0] len, input logic [7:0] pc, input string name);
    ins_t ex, a;
    ex = '{op, opnd, len, pc};
    a  = (idx < dq.size()) ? dq[idx] : '0;
    check(a === ex, name, {10'b0, a}, {10'b0, ex});
  endtask

  task automatic redirect_to(input logic [7:0] pc, input string name);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 check(mem_rd === 1'b1 && mem_addr === pc, name, {23'b0, mem_rd, mem_addr}, {23'b0, 1'b1, pc});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r0, i;
    for (int a = 0; a < 256; a++) prog[a] = NOP;
    prog[8'h00] = MVA; prog[8'h01] = 4'h5; prog[8'h02] = ADD; prog[8'h03] = HLT;
    prog[8'h10] = JMP; prog[8'h11] = 4'h4; prog[8'h12] = 4'hA; prog[8'h13] = ADD; prog[8'h14] = SUB;
    prog[8'h20] = ADD;
    prog[8'h30] = MVA; prog[8'h31] = 4'h1; prog[8'h32] = MVB; prog[8'h33] = 4'h2;
    prog[8'h34] = ADD; prog[8'h35] = SUB; prog[8'h36] = MAB;
    prog[8'hA4] = MVB; prog[8'hA5] = 4'h6;
    prog[8'hFE] = MVB; prog[8'hFF] = 4'h3;

    repeat (3) @(negedge clk);
    check(all_outs() === 32'd0, "reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    ins_ready = 1'b1;
    #1 check(mem_rd === 1'b1 && mem_addr === 8'h00, "first_fetch", {23'b0, mem_rd, mem_addr}, 32'h100);

    // Basic stream from reset
    wait_deliv(3, "t1_wait");
    check_ins(0, MVA, 8'h05, 2'd1, 8'h00, "t1_mva");
    check_ins(1, ADD, 8'h00, 2'd0, 8'h02, "t1_add");
    check_ins(2, HLT, 8'h00, 2'd0, 8'h03, "t1_hlt");
    r0 = n_reads;
    repeat (12) @(negedge clk);
`ifdef PREFETCH_HLT_STOP_EN
    check(n_reads == r0 && !ins_valid && !mem_rd, "hlt_stop", n_reads - r0, 0);
    redirect_to(8'h20, "hlt_resume_fetch");
    base = dq.size();
    wait_deliv(base + 1, "hlt_resume_wait");
    check_ins(base, ADD, 8'h00, 2'd0, 8'h20, "hlt_resume_ins");
`else
    check(n_reads > r0, "hlt_continue", n_reads - r0, 1);
`endif

    // JMP, redirect in the same cycle as its handshake
    redirect_to(8'h10, "t2_redir");
    base = dq.size();
    i = 0;
    while (!(ins_valid && ins_op == JMP) && i < 50) begin
      @(negedge clk);
      i++;
    end
    check(ins_valid && ins_op == JMP, "t2_jmp_seen", {27'b0, ins_valid, ins_op}, {27'b0, 1'b1, JMP});
    redirect_to(8'hA4, "t2_redir_a4");
    wait_deliv(base + 2, "t2_wait");
    check_ins(base, JMP, 8'hA4, 2'd2, 8'h10, "t2_jmp");
    check_ins(base + 1, MVB, 8'h06, 2'd1, 8'hA4, "t2_target");

    // Backpressure: hold ins_ready low, FIFO fills, fetch stops
    ins_ready = 1'b0;
    redirect_to(8'h30, "t3_redir");
    repeat (3) @(negedge clk);
    check(!ins_valid, "t3_lat_early", {31'b0, ins_valid}, 32'd0);
    @(negedge clk);
    check(ins_valid, "t3_lat", {31'b0, ins_valid}, 32'd1);
    repeat (10) @(negedge clk);
    r0 = n_reads;
    repeat (10) @(negedge clk);
    check(n_reads == r0 && !mem_rd, "t3_fetch_stopped", n_reads - r0, 0);
    check(last_rd == 8'h35, "t3_fifo_full", {24'b0, last_rd}, 32'h35);
    check(ins_valid && ins_op == MVA && ins_opnd == 8'h01 && ins_pc == 8'h30, "t3_held",
          {11'b0, ins_valid, ins_op, ins_opnd, ins_pc}, {11'b0, 1'b1, MVA, 8'h01, 8'h30});
    base = dq.size();
    ins_ready = 1'b1;
    wait_deliv(base + 5, "t3_wait");
    check_ins(base,     MVA, 8'h01, 2'd1, 8'h30, "t3_mva");
    check_ins(base + 1, MVB, 8'h02, 2'd1, 8'h32, "t3_mvb");
    check_ins(base + 4, MAB, 8'h00, 2'd0, 8'h36, "t3_mab");

    // Address wrap
    prog[8'h00] = MAB;
    prog[8'h01] = NOP;
    redirect_to(8'hFE, "t4_redir");
    base = dq.size();
    wait_deliv(base + 2, "t4_wait");
    check_ins(base,     MVB, 8'h03, 2'd1, 8'hFE, "t4_mvb");
    check_ins(base + 1, MAB, 8'h00, 2'd0, 8'h00, "t4_wrap");

    // Redirect during a read, then reset in the middle of a JMP
    i = 0;
    while (!mem_rd && i < 20) begin
      @(negedge clk);
      i++;
    end
    check(mem_rd, "t5_rd_seen", {31'b0, mem_rd}, 32'd1);
    redirect_to(8'h10, "t5_redir");
    prog[8'h00] = MVA;
    prog[8'h01] = 4'h5;
    i = 0;
    while (!(ins_op == JMP && !ins_valid) && i < 20) begin
      @(negedge clk);
      i++;
    end
    check(ins_op == JMP && !ins_valid, "t5_mid_jmp", {27'b0, ins_valid, ins_op}, {27'b0, 1'b0, JMP});
    base = dq.size();
    reset = 1'b1;
    @(negedge clk);
    check(all_outs() === 32'd0, "t5_reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check(mem_rd === 1'b1 && mem_addr === 8'h00, "t5_restart", {23'b0, mem_rd, mem_addr}, 32'h100);
    wait_deliv(base + 1, "t5_wait");
    check_ins(base, MVA, 8'h05, 2'd1, 8'h00, "t5_first");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
